// File: rtl/cache_types_pkg.sv
// -----------------------------------------------------------------------------
// cache_types_pkg
// Shared types and constants for the direct-mapped L1 cache:
//   OFFSET_BITS / LINE_BITS / WORD_BITS  line geometry (16-byte lines, 16-bit words)
//   line_t                               one 128-bit cache line
//   cache_state_t                        controller states
//   merge_word()                         byte-lane merge of CPU write data into a line
// -----------------------------------------------------------------------------
package cache_types_pkg;

   localparam int OFFSET_BITS = 4;
   localparam int LINE_BITS   = 128;
   localparam int WORD_BITS   = 16;

   typedef logic [LINE_BITS-1:0] line_t;

   typedef enum logic [1:0] {
      CHECK     = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } cache_state_t;

   // Replace the enabled bytes of word w; all other bits of the line are kept.
   function automatic line_t merge_word(input line_t                line,
                                        input logic [2:0]           w,
                                        input logic [WORD_BITS-1:0] wdata,
                                        input logic [1:0]           be);
      line_t res;
      res = line;
      for (int b = 0; b < 2; b++) begin
         if (be[b]) begin
            res[int'(w)*WORD_BITS + b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cache_array.sv
// -----------------------------------------------------------------------------
// cache_array
// Flop array of NUM_SETS entries, WIDTH bits each. Asynchronous active-high
// clear, one synchronous write port, combinational read at the same index.
//   clk, rst     clock / asynchronous clear of every entry
//   we_i         write enable
//   idx_i        entry index, shared by read and write
//   wdata_i      write data
//   rdata_o      entry idx_i, combinational
// -----------------------------------------------------------------------------
module cache_array #(
   parameter int WIDTH    = 1,
   parameter int NUM_SETS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we_i,
   input  logic [$clog2(NUM_SETS)-1:0] idx_i,
   input  logic [WIDTH-1:0]            wdata_i,
   output logic [WIDTH-1:0]            rdata_o
);

   logic [WIDTH-1:0] mem_q [NUM_SETS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SETS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/l1_cache_dm.sv
// -----------------------------------------------------------------------------
// l1_cache_dm
// Direct-mapped, write-back, write-allocate L1 cache (16-bit CPU words,
// 128-bit lines to the arbiter).
//   CPU side : mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
//              -> mem_rdata, mem_resp (hit responds in the same cycle)
//   Mem side : pmem_read, pmem_write, pmem_address, pmem_wdata
//              <- pmem_rdata, pmem_resp
// Address: [3:1] word, [3+log2(NUM_SETS):4] index, remaining upper bits tag.
// -----------------------------------------------------------------------------
module l1_cache_dm
   import cache_types_pkg::*;
#(
   parameter int NUM_SETS = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic [1:0]    mem_byte_enable,
   input  logic [15:0]   mem_address,
   input  logic [15:0]   mem_wdata,
   output logic [15:0]   mem_rdata,
   output logic          mem_resp,
   output logic          pmem_read,
   output logic          pmem_write,
   output logic [15:0]   pmem_address,
   output logic [127:0]  pmem_wdata,
   input  logic [127:0]  pmem_rdata,
   input  logic          pmem_resp
);

   localparam int IDX_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = 16 - OFFSET_BITS - IDX_BITS;

   cache_state_t        state_q, state_d;

   logic [IDX_BITS-1:0] idx;
   logic [TAG_BITS-1:0] req_tag, line_tag;
   logic [2:0]          word_sel;
   line_t               line_data, data_wdata;
   logic                line_valid, line_dirty;
   logic                req, hit, wr_hit, fill, wb_done;
   logic                data_we, dirty_we;
   logic                addr_unused;

   assign idx         = mem_address[OFFSET_BITS +: IDX_BITS];
   assign req_tag     = mem_address[15 -: TAG_BITS];
   assign word_sel    = mem_address[3:1];
   assign addr_unused = mem_address[0];

   // Read+write together is treated as a write; mem_write alone selects the merge.
   assign req     = mem_read | mem_write;
   assign hit     = req & line_valid & (line_tag == req_tag);
   assign wr_hit  = (state_q == CHECK) & hit & mem_write;
   assign fill    = (state_q == ALLOCATE) & pmem_resp;
   assign wb_done = (state_q == WRITEBACK) & pmem_resp;

   assign data_we    = wr_hit | fill;
   assign data_wdata = fill ? pmem_rdata
                            : merge_word(line_data, word_sel, mem_wdata, mem_byte_enable);
   // Dirty is set by a write hit and cleared by both writeback and fill completion.
   assign dirty_we   = wr_hit | wb_done | fill;

   cache_array #(.WIDTH(LINE_BITS), .NUM_SETS(NUM_SETS)) u_data (
      .clk(clk), .rst(rst), .we_i(data_we), .idx_i(idx),
      .wdata_i(data_wdata), .rdata_o(line_data));

   cache_array #(.WIDTH(TAG_BITS), .NUM_SETS(NUM_SETS)) u_tag (
      .clk(clk), .rst(rst), .we_i(fill), .idx_i(idx),
      .wdata_i(req_tag), .rdata_o(line_tag));

   cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS)) u_valid (
      .clk(clk), .rst(rst), .we_i(fill), .idx_i(idx),
      .wdata_i(1'b1), .rdata_o(line_valid));

   cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS)) u_dirty (
      .clk(clk), .rst(rst), .we_i(dirty_we), .idx_i(idx),
      .wdata_i(wr_hit), .rdata_o(line_dirty));

   assign mem_rdata = line_data[int'(word_sel)*WORD_BITS +: WORD_BITS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CHECK;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CHECK: begin
            if (req && !hit) begin
               state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            if (pmem_resp) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            if (pmem_resp) state_d = CHECK;
         end
         default: state_d = CHECK;
      endcase
   end

   always_comb begin
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      case (state_q)
         CHECK: begin
            mem_resp = hit;
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {line_tag, idx, 4'h0};
            pmem_wdata   = line_data;
         end
         ALLOCATE: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, idx, 4'h0};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_l1_cache_dm.sv
// -----------------------------------------------------------------------------
// tb_l1_cache_dm
// Directed scenarios followed by random traffic against a behavioural cache
// model. An L2 responder answers every pmem request 3 cycles after it rises.
// -----------------------------------------------------------------------------
module tb_l1_cache_dm;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_read, mem_write;
   logic [1:0]    mem_byte_enable;
   logic [15:0]   mem_address, mem_wdata, mem_rdata;
   logic          mem_resp, pmem_read, pmem_write, pmem_resp;
   logic [15:0]   pmem_address;
   logic [127:0]  pmem_wdata, pmem_rdata;

   l1_cache_dm #(.NUM_SETS(8)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp));

   always #5 clk = ~clk;

   typedef struct packed {
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] data;
   } ev_t;

   ev_t act_ev[$];
   ev_t exp_ev[$];

   int tests = 0;
   int fails = 0;

   logic [127:0] l2_mem  [logic [15:0]];
   logic [127:0] ref_mem [logic [15:0]];

   logic         ref_valid [8];
   logic         ref_dirty [8];
   int           ref_tag   [8];
   logic [127:0] ref_line  [8];

   bit viol_both = 0;
   bit viol_hold = 0;

   function automatic logic [127:0] pat(input logic [15:0] base);
      logic [127:0] l;
      for (int k = 0; k < 8; k++) begin
         l[k*16 +: 16] = base ^ (16'h1111 * 16'(k)) ^ 16'h5A5A;
      end
      return l;
   endfunction

   function automatic logic [127:0] l2_get(input logic [15:0] base);
      if (l2_mem.exists(base)) return l2_mem[base];
      return pat(base);
   endfunction

   function automatic logic [127:0] ref_get(input logic [15:0] base);
      if (ref_mem.exists(base)) return ref_mem[base];
      return pat(base);
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         ref_valid[i] = 0;
         ref_dirty[i] = 0;
         ref_tag[i]   = 0;
         ref_line[i]  = '0;
      end
   endtask

   // L2 responder: pulse pmem_resp on the 3rd cycle a request is seen.
   int           l2_cnt;
   logic [15:0]  st_addr;
   logic [127:0] st_wdata;
   logic         st_kind;
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      l2_cnt     = 0;
      forever begin
         @(negedge clk);
         if (pmem_read && pmem_write) viol_both = 1;
         if (pmem_resp) begin
            pmem_resp = 1'b0;
            l2_cnt    = 0;
         end
         if (rst) begin
            l2_cnt = 0;
         end else if (pmem_read || pmem_write) begin
            l2_cnt++;
            if (l2_cnt == 1) begin
               st_addr  = pmem_address;
               st_wdata = pmem_wdata;
               st_kind  = pmem_write;
            end else if (pmem_address !== st_addr || pmem_wdata !== st_wdata ||
                         pmem_write !== st_kind) begin
               viol_hold = 1;
            end
            if (l2_cnt == 3) begin
               pmem_resp = 1'b1;
               if (pmem_write) begin
                  l2_mem[pmem_address] = pmem_wdata;
                  act_ev.push_back('{wr: 1'b1, addr: pmem_address, data: pmem_wdata});
               end else begin
                  pmem_rdata = l2_get(pmem_address);
                  act_ev.push_back('{wr: 1'b0, addr: pmem_address, data: '0});
               end
            end
         end else begin
            l2_cnt = 0;
         end
      end
   end

   // Reference behaviour of one access: expected read data, latency and pmem traffic.
   task automatic model_access(input bit wr, input logic [15:0] a, input logic [1:0] be,
                               input logic [15:0] wd, output logic [15:0] erd, output int elat);
      int idx, tg, w;
      logic [15:0] base;
      idx = (int'(a) >> 4) % 8;
      tg  = int'(a) >> 7;
      w   = (int'(a) >> 1) % 8;
      elat = 0;
      if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
         elat = 4;
         if (ref_valid[idx] && ref_dirty[idx]) begin
            base = 16'((ref_tag[idx] << 7) | (idx << 4));
            ref_mem[base] = ref_line[idx];
            exp_ev.push_back('{wr: 1'b1, addr: base, data: ref_line[idx]});
            elat = 7;
         end
         base = a & 16'hFFF0;
         exp_ev.push_back('{wr: 1'b0, addr: base, data: '0});
         ref_line[idx]  = ref_get(base);
         ref_valid[idx] = 1;
         ref_dirty[idx] = 0;
         ref_tag[idx]   = tg;
      end
      erd = ref_line[idx][w*16 +: 16];
      if (wr) begin
         if (be[0]) ref_line[idx][w*16 +: 8]     = wd[7:0];
         if (be[1]) ref_line[idx][w*16 + 8 +: 8] = wd[15:8];
         ref_dirty[idx] = 1;
      end
   endtask

   // Present a request at a negedge and hold it until mem_resp (bounded).
   task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [1:0] be, input logic [15:0] wd,
                         output logic [15:0] rdat, output int lat);
      bit got;
      got  = 0;
      lat  = -1;
      rdat = '0;
      mem_read = rd; mem_write = wr; mem_address = a;
      mem_byte_enable = be; mem_wdata = wd;
      for (int c = 0; c < 40 && !got; c++) begin
         #1;
         if (mem_resp) begin
            got  = 1;
            rdat = mem_rdata;
            lat  = c;
         end else begin
            @(negedge clk);
         end
      end
      if (got) begin
         @(posedge clk);
         @(negedge clk);
      end
      mem_read = 0; mem_write = 0;
   endtask

   task automatic access(input string name, input bit rd, input bit wr, input logic [15:0] a,
                         input logic [1:0] be, input logic [15:0] wd, output logic [15:0] ard);
      logic [15:0] erd;
      int elat, alat;
      ev_t ea, ee;
      model_access(wr, a, be, wd, erd, elat);
      do_req(rd, wr, a, be, wd, ard, alat);
      chk({name, " latency"}, 128'(alat), 128'(elat));
      chk({name, " rdata"}, 128'(ard), 128'(erd));
      chk({name, " pmem count"}, 128'(act_ev.size()), 128'(exp_ev.size()));
      while (act_ev.size() > 0 && exp_ev.size() > 0) begin
         ea = act_ev.pop_front();
         ee = exp_ev.pop_front();
         chk({name, " pmem kind"}, 128'(ea.wr), 128'(ee.wr));
         chk({name, " pmem addr"}, 128'(ea.addr), 128'(ee.addr));
         chk({name, " pmem wdata"}, ea.data, ee.data);
      end
      act_ev.delete();
      exp_ev.delete();
   endtask

   initial begin
      logic [15:0] rd;
      logic [127:0] l;
      int k;
      logic [15:0] a;

      // L2 contents named by the directed scenarios
      l = pat(16'h1230);
      l[47:32] = 16'hBEEF;
      l2_mem[16'h1230]  = l;
      ref_mem[16'h1230] = l;
      l2_mem[16'h0000]  = {8{16'h1111}};
      ref_mem[16'h0000] = {8{16'h1111}};
      model_reset();

      rst = 1; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
      mem_address = 0; mem_wdata = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      #1;
      chk("reset mem_resp", 128'(mem_resp), 128'(0));
      chk("reset mem_rdata", 128'(mem_rdata), 128'(0));
      chk("reset pmem_read", 128'(pmem_read), 128'(0));
      chk("reset pmem_write", 128'(pmem_write), 128'(0));
      chk("reset pmem_address", 128'(pmem_address), 128'(0));
      chk("reset pmem_wdata", pmem_wdata, 128'(0));
      @(negedge clk);

      access("cold read", 1, 0, 16'h1234, 2'b00, 16'h0000, rd);
      chk("cold read value", 128'(rd), 128'(16'hBEEF));
      access("re-read hit", 1, 0, 16'h1234, 2'b00, 16'h0000, rd);
      access("write hit", 0, 1, 16'h1234, 2'b01, 16'hAA55, rd);
      access("read after write", 1, 0, 16'h1234, 2'b00, 16'h0000, rd);
      chk("merged value", 128'(rd), 128'(16'hBE55));
      access("dirty conflict", 1, 0, 16'h9234, 2'b00, 16'h0000, rd);
      access("clean conflict", 1, 0, 16'h1234, 2'b00, 16'h0000, rd);
      access("write miss", 0, 1, 16'h0006, 2'b10, 16'h7700, rd);
      access("write miss readback", 1, 0, 16'h0006, 2'b00, 16'h0000, rd);
      chk("write miss value", 128'(rd), 128'(16'h7711));
      access("idle", 1, 0, 16'h0000, 2'b00, 16'h0000, rd);
      access("be00 write", 0, 1, 16'h0004, 2'b00, 16'hFFFF, rd);
      access("be00 evict", 1, 0, 16'h0086, 2'b00, 16'h0000, rd);
      access("read+write", 1, 1, 16'h0082, 2'b11, 16'hC0DE, rd);
      access("read+write readback", 1, 0, 16'h0082, 2'b00, 16'h0000, rd);

      // Reset while a fill is outstanding
      @(negedge clk);
      mem_read = 1; mem_address = 16'h5678;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (pmem_read) break;
      end
      chk("fill started", 128'(pmem_read), 128'(1));
      rst = 1;
      #1;
      chk("reset drops pmem_read", 128'(pmem_read), 128'(0));
      chk("reset drops pmem_address", 128'(pmem_address), 128'(0));
      chk("reset mem_resp low", 128'(mem_resp), 128'(0));
      mem_read = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      model_reset();
      chk("no pmem completion across reset", 128'(act_ev.size()), 128'(0));
      act_ev.delete();
      @(negedge clk);
      access("read after reset", 1, 0, 16'h5678, 2'b00, 16'h0000, rd);

      // Random traffic over a few tags to force conflicts
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 9);
         a = (16'($urandom_range(0, 3)) << 7) | 16'($urandom_range(0, 127));
         if (k < 5)
            access("random read", 1, 0, a, 2'b00, 16'h0000, rd);
         else if (k < 9)
            access("random write", 0, 1, a, 2'($urandom_range(0, 3)), 16'($urandom), rd);
         else
            access("random read+write", 1, 1, a, 2'($urandom_range(0, 3)), 16'($urandom), rd);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      chk("pmem_read and pmem_write exclusive", 128'(viol_both), 128'(0));
      chk("pmem request held stable", 128'(viol_hold), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
